// File: rtl/display_pkg.sv
// Shared constants for the 7-segment display reader: segment patterns
// (active-low, {g..a}), anode position codes and the frame FSM states.
package display_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_6_ALT = 7'h03;
    localparam logic [6:0] SEG_7_ALT = 7'h58;
    localparam logic [6:0] SEG_9_ALT = 7'h18;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] AN_UNI = 4'b1110;
    localparam logic [3:0] AN_DEC = 4'b1101;
    localparam logic [3:0] AN_CEN = 4'b1011;
    localparam logic [3:0] AN_SIG = 4'b0111;

    typedef enum logic {
        SCAN,
        EMIT
    } state_t;

endpackage

// File: rtl/sseg_decode.sv
// Combinational 7-segment to BCD decoder; flags any pattern that is not
// a recognised digit shape (including the tail variants of 6, 7 and 9).
module sseg_decode
    import display_pkg::*;
(
    input  logic [6:0] seg,
    output logic       bad,
    output logic [3:0] bcd
);

    always_comb begin
        bad = 1'b0;
        bcd = 4'd0;
        case (seg)
            SEG_0:            bcd = 4'd0;
            SEG_1:            bcd = 4'd1;
            SEG_2:            bcd = 4'd2;
            SEG_3:            bcd = 4'd3;
            SEG_4:            bcd = 4'd4;
            SEG_5:            bcd = 4'd5;
            SEG_6, SEG_6_ALT: bcd = 4'd6;
            SEG_7, SEG_7_ALT: bcd = 4'd7;
            SEG_8:            bcd = 4'd8;
            SEG_9, SEG_9_ALT: bcd = 4'd9;
            default:          bad = 1'b1;
        endcase
    end

endmodule

// File: rtl/display_num_reader.sv
// Reads a scanned 4-digit 7-segment display back into an 8-bit value,
// capturing each digit once it is stable and validating the whole frame.
module display_num_reader
    import display_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] SSeg_in,
    input  logic [3:0] an_in,
    output logic [7:0] valor,
    output logic       valid,
    output logic       err
);

    localparam int            CW         = $clog2(SETTLE + 1);
    localparam logic [CW-1:0] SETTLE_CNT = CW'(SETTLE);

    logic [10:0] sample;

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign sample = {an_in, SSeg_in};
        end else begin : g_sync
            logic [SYNC_STAGES-1:0][10:0] sync_q, sync_d;

            always_comb begin
                sync_d    = sync_q;
                sync_d[0] = {an_in, SSeg_in};
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    sync_d[i] = sync_q[i-1];
                end
            end

            // Cleared to all-ones so the idle state looks like a blanked display.
            always_ff @(posedge clk) begin
                if (!rst_n) sync_q <= '1;
                else        sync_q <= sync_d;
            end

            assign sample = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    logic [3:0] an_s;
    logic [6:0] seg_s;
    logic       dig_bad;
    logic [3:0] dig_bcd;

    assign an_s  = sample[10:7];
    assign seg_s = sample[6:0];

    sseg_decode u_dec (
        .seg (seg_s),
        .bad (dig_bad),
        .bcd (dig_bcd)
    );

    state_t        state_q, state_d;
    logic [10:0]   prev_q, prev_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          captured_q, captured_d;
    logic [3:0]    mask_q, mask_d;
    logic [3:0]    bad_q, bad_d;
    logic [3:0]    uni_q, uni_d, dec_q, dec_d, cen_q, cen_d;
    logic [7:0]    valor_q, valor_d;
    logic          valid_q, valid_d, err_q, err_d;

    logic          pos_ok, same, cap, reject;
    logic [9:0]    h10, t10, u10, sum;

    always_comb begin
        case (an_s)
            AN_UNI, AN_DEC, AN_CEN, AN_SIG: pos_ok = 1'b1;
            default:                        pos_ok = 1'b0;
        endcase
    end

    // H*100 + T*10 + U using shift-add only.
    always_comb begin
        h10    = {6'd0, cen_q};
        t10    = {6'd0, dec_q};
        u10    = {6'd0, uni_q};
        sum    = (h10 << 6) + (h10 << 5) + (h10 << 2) + (t10 << 3) + (t10 << 1) + u10;
        reject = (|bad_q) || (sum > 10'd255);
    end

    always_comb begin
        state_d    = state_q;
        prev_d     = sample;
        cnt_d      = cnt_q;
        captured_d = captured_q;
        mask_d     = mask_q;
        bad_d      = bad_q;
        uni_d      = uni_q;
        dec_d      = dec_q;
        cen_d      = cen_q;
        valor_d    = valor_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        same       = (sample == prev_q);

        if (!pos_ok)                 cnt_d = '0;
        else if (!same)              cnt_d = CW'(1);
        else if (cnt_q != SETTLE_CNT) cnt_d = cnt_q + CW'(1);

        if (!same) captured_d = 1'b0;
        cap = pos_ok && (cnt_d == SETTLE_CNT) && !(same && captured_q);
        if (cap) captured_d = 1'b1;

        case (state_q)
            SCAN: begin
                if (cap) begin
                    mask_d = mask_q | ~an_s;
                    case (an_s)
                        AN_UNI: begin uni_d = dig_bcd; bad_d[0] = dig_bad; end
                        AN_DEC: begin dec_d = dig_bcd; bad_d[1] = dig_bad; end
                        AN_CEN: begin cen_d = dig_bcd; bad_d[2] = dig_bad; end
                        AN_SIG: bad_d[3] = (seg_s != SEG_BLANK);
                        default: ;
                    endcase
                    if (mask_d == 4'hF) state_d = EMIT;
                end
            end
            EMIT: begin
                if (reject) begin
                    err_d = 1'b1;
                end else begin
                    valid_d = 1'b1;
                    valor_d = sum[7:0];
                end
                mask_d  = 4'h0;
                state_d = SCAN;
            end
            default: state_d = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= SCAN;
            prev_q     <= '1;
            cnt_q      <= '0;
            captured_q <= 1'b0;
            mask_q     <= 4'h0;
            bad_q      <= 4'h0;
            uni_q      <= 4'd0;
            dec_q      <= 4'd0;
            cen_q      <= 4'd0;
            valor_q    <= 8'd0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            cnt_q      <= cnt_d;
            captured_q <= captured_d;
            mask_q     <= mask_d;
            bad_q      <= bad_d;
            uni_q      <= uni_d;
            dec_q      <= dec_d;
            cen_q      <= cen_d;
            valor_q    <= valor_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign valor = valor_q;
    assign valid = valid_q;
    assign err   = err_q;

endmodule

// File: tb/tb_display_num_reader.sv
// Self-checking bench for display_num_reader: directed frames plus random
// frames scored against a digit-table / arithmetic reference model.
module tb_display_num_reader;

    localparam int SETTLE = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] SSeg_in;
    logic [3:0] an_in;
    logic [7:0] valor;
    logic       valid;
    logic       err;

    int         checks   = 0;
    int         failures = 0;
    int         n_valid  = 0;
    int         n_err    = 0;
    int         n_both   = 0;
    logic [7:0] exp_valor = 8'd0;

    logic [6:0] legal_pat [13] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02,
                                   7'h78, 7'h00, 7'h10, 7'h03, 7'h58, 7'h18};
    int         legal_val [13] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 6, 7, 9};

    always #5 clk = ~clk;

    display_num_reader #(
        .SYNC_STAGES (2),
        .SETTLE      (SETTLE)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .SSeg_in (SSeg_in),
        .an_in   (an_in),
        .valor   (valor),
        .valid   (valid),
        .err     (err)
    );

    // Pulse monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (valid === 1'b1) n_valid++;
        if (err === 1'b1) n_err++;
        if (valid === 1'b1 && err === 1'b1) n_both++;
    end

    // Reference model: digit value from the legal-pattern table, -1 if illegal.
    function automatic int model_digit(input logic [6:0] p);
        for (int i = 0; i < 13; i++) begin
            if (legal_pat[i] == p) return legal_val[i];
        end
        return -1;
    endfunction

    // Frame value 0..255, or -1 when the frame must be rejected.
    function automatic int model_frame(input logic [6:0] u, input logic [6:0] t,
                                       input logic [6:0] h, input logic [6:0] s);
        int du, dt, dh, v;
        du = model_digit(u);
        dt = model_digit(t);
        dh = model_digit(h);
        if (du < 0 || dt < 0 || dh < 0 || s != 7'h7F) return -1;
        v = dh * 100 + dt * 10 + du;
        return (v > 255) ? -1 : v;
    endfunction

    task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
        an_in   = an;
        SSeg_in = seg;
        repeat (n) @(negedge clk);
    endtask

    // Scans one frame (optionally preceded by a short units glitch) and
    // reports how many valid/err pulses appeared during it.
    task automatic run_frame(input logic [6:0] u, input logic [6:0] t,
                             input logic [6:0] h, input logic [6:0] s,
                             input int dwell, input int gap,
                             input int glitch_len, input logic [6:0] gpat,
                             output int dv, output int de);
        int v0, e0;
        v0 = n_valid;
        e0 = n_err;
        if (glitch_len > 0) drive(4'b1110, gpat, glitch_len);
        drive(4'b1110, u, dwell);
        drive(4'b1111, 7'h7F, gap);
        drive(4'b1101, t, dwell);
        drive(4'b1111, 7'h7F, gap);
        drive(4'b1011, h, dwell);
        drive(4'b1111, 7'h7F, gap);
        drive(4'b0111, s, dwell);
        drive(4'b1111, 7'h7F, 12);
        dv = n_valid - v0;
        de = n_err - e0;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        an_in   = 4'b1111;
        SSeg_in = 7'h7F;
        repeat (3) @(negedge clk);
        checks++;
        if (valor !== 8'd0) begin failures++; $display("[TB] FAIL reset_valor got=%0d exp=0", valor); end
        checks++;
        if (valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", valid); end
        checks++;
        if (err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got=%b exp=0", err); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_scan_255();
        int dv, de;
        run_frame(7'h12, 7'h12, 7'h24, 7'h7F, 10, 0, 0, 7'h00, dv, de);
        exp_valor = 8'd255;
        checks++;
        if (dv !== 1) begin failures++; $display("[TB] FAIL s255_valid got=%0d exp=1", dv); end
        checks++;
        if (de !== 0) begin failures++; $display("[TB] FAIL s255_err got=%0d exp=0", de); end
        checks++;
        if (valor !== exp_valor) begin failures++; $display("[TB] FAIL s255_valor got=%0d exp=%0d", valor, exp_valor); end
    endtask

    task automatic test_zero_then_128();
        int dv, de;
        run_frame(7'h40, 7'h40, 7'h40, 7'h7F, 10, 0, 0, 7'h00, dv, de);
        exp_valor = 8'd0;
        checks++;
        if (dv !== 1 || de !== 0) begin failures++; $display("[TB] FAIL s0_pulses got valid=%0d err=%0d exp 1/0", dv, de); end
        checks++;
        if (valor !== exp_valor) begin failures++; $display("[TB] FAIL s0_valor got=%0d exp=%0d", valor, exp_valor); end
        run_frame(7'h00, 7'h24, 7'h79, 7'h7F, 10, 0, 0, 7'h00, dv, de);
        exp_valor = 8'd128;
        checks++;
        if (dv !== 1 || de !== 0) begin failures++; $display("[TB] FAIL s128_pulses got valid=%0d err=%0d exp 1/0", dv, de); end
        checks++;
        if (valor !== exp_valor) begin failures++; $display("[TB] FAIL s128_valor got=%0d exp=%0d", valor, exp_valor); end
    endtask

    task automatic test_overflow_256();
        int dv, de;
        run_frame(7'h02, 7'h12, 7'h24, 7'h7F, 10, 0, 0, 7'h00, dv, de);
        checks++;
        if (de !== 1) begin failures++; $display("[TB] FAIL s256_err got=%0d exp=1", de); end
        checks++;
        if (dv !== 0) begin failures++; $display("[TB] FAIL s256_valid got=%0d exp=0", dv); end
        checks++;
        if (valor !== exp_valor) begin failures++; $display("[TB] FAIL s256_valor got=%0d exp=%0d", valor, exp_valor); end
    endtask

    task automatic test_bad_patterns();
        int dv, de;
        run_frame(7'h12, 7'h7E, 7'h79, 7'h7F, 10, 2, 0, 7'h00, dv, de);
        checks++;
        if (de !== 1 || dv !== 0) begin failures++; $display("[TB] FAIL bad_tens got valid=%0d err=%0d exp 0/1", dv, de); end
        checks++;
        if (valor !== exp_valor) begin failures++; $display("[TB] FAIL bad_tens_valor got=%0d exp=%0d", valor, exp_valor); end
        run_frame(7'h12, 7'h12, 7'h79, 7'h3F, 10, 2, 0, 7'h00, dv, de);
        checks++;
        if (de !== 1 || dv !== 0) begin failures++; $display("[TB] FAIL bad_sign got valid=%0d err=%0d exp 0/1", dv, de); end
        checks++;
        if (valor !== exp_valor) begin failures++; $display("[TB] FAIL bad_sign_valor got=%0d exp=%0d", valor, exp_valor); end
    endtask

    task automatic test_glitch();
        int dv, de;
        // Units shows a 5 for one sample short of settling, then the real 3.
        run_frame(7'h30, 7'h19, 7'h79, 7'h7F, 10, 3, SETTLE - 1, 7'h12, dv, de);
        exp_valor = 8'd143;
        checks++;
        if (dv !== 1 || de !== 0) begin failures++; $display("[TB] FAIL glitch_pulses got valid=%0d err=%0d exp 1/0", dv, de); end
        checks++;
        if (valor !== exp_valor) begin failures++; $display("[TB] FAIL glitch_valor got=%0d exp=%0d", valor, exp_valor); end
    endtask

    task automatic test_reset_mid_frame();
        int v0, e0, dv, de;
        v0 = n_valid;
        e0 = n_err;
        drive(4'b1110, 7'h10, 10);
        drive(4'b1101, 7'h10, 10);
        drive(4'b1011, 7'h79, 10);
        drive(4'b1111, 7'h7F, 4);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'b1111, 7'h7F, 12);
        exp_valor = 8'd0;
        checks++;
        if (n_valid - v0 !== 0 || n_err - e0 !== 0) begin
            failures++;
            $display("[TB] FAIL midrst_quiet got valid=%0d err=%0d exp 0/0", n_valid - v0, n_err - e0);
        end
        checks++;
        if (valor !== exp_valor) begin failures++; $display("[TB] FAIL midrst_valor got=%0d exp=%0d", valor, exp_valor); end
        run_frame(7'h24, 7'h19, 7'h40, 7'h7F, 10, 0, 0, 7'h00, dv, de);
        exp_valor = 8'd42;
        checks++;
        if (dv !== 1 || de !== 0) begin failures++; $display("[TB] FAIL rescan_pulses got valid=%0d err=%0d exp 1/0", dv, de); end
        checks++;
        if (valor !== exp_valor) begin failures++; $display("[TB] FAIL rescan_valor got=%0d exp=%0d", valor, exp_valor); end
    endtask

    function automatic logic [6:0] pick_digit(input bit low_bias);
        logic [6:0] r;
        if ($urandom_range(0, 7) == 0) begin
            r = 7'($urandom);
            return r;
        end
        if (low_bias && $urandom_range(0, 1) == 1) return legal_pat[$urandom_range(0, 2)];
        return legal_pat[$urandom_range(0, 12)];
    endfunction

    task automatic test_random();
        int dv, de, expv, dwell, gap;
        logic [6:0] u, t, h, s;
        for (int n = 0; n < 20; n++) begin
            u = pick_digit(1'b0);
            t = pick_digit(1'b0);
            h = pick_digit(1'b1);
            s = ($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'h7F;
            dwell = $urandom_range(SETTLE, 12);
            gap   = $urandom_range(0, 3);
            expv  = model_frame(u, t, h, s);
            run_frame(u, t, h, s, dwell, gap, 0, 7'h00, dv, de);
            if (expv >= 0) exp_valor = 8'(expv);
            checks++;
            if (dv !== ((expv >= 0) ? 1 : 0)) begin
                failures++;
                $display("[TB] FAIL rand%0d_valid got=%0d exp=%0d (u=%h t=%h h=%h s=%h)", n, dv, (expv >= 0) ? 1 : 0, u, t, h, s);
            end
            checks++;
            if (de !== ((expv < 0) ? 1 : 0)) begin
                failures++;
                $display("[TB] FAIL rand%0d_err got=%0d exp=%0d (u=%h t=%h h=%h s=%h)", n, de, (expv < 0) ? 1 : 0, u, t, h, s);
            end
            checks++;
            if (valor !== exp_valor) begin
                failures++;
                $display("[TB] FAIL rand%0d_valor got=%0d exp=%0d", n, valor, exp_valor);
            end
        end
    endtask

    task automatic test_exclusive();
        checks++;
        if (n_both !== 0) begin failures++; $display("[TB] FAIL valid_err_overlap got=%0d exp=0", n_both); end
    endtask

    initial begin
        test_reset();
        test_scan_255();
        test_zero_then_128();
        test_overflow_256();
        test_bad_patterns();
        test_glitch();
        test_reset_mid_frame();
        test_random();
        test_exclusive();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
